// File: rtl/zap_predecode_coproc_mc_if.sv
// Predecode-to-decode/coprocessor bundle for zap_predecode_coproc_mc.
// master = fetch/pipeline side driving the instruction stream,
// slave  = the coprocessor dispatch stage.
interface zap_predecode_coproc_mc_if #(
  parameter int NUM_CP   = 4,
  parameter int PHY_REGS = 46
);
  localparam int REG_W = $clog2(PHY_REGS);

  // Instruction stream from fetch/compress
  logic [31:0]       i_instruction;
  logic              i_valid;
  logic [31:0]       i_cpsr_ff;
  logic              i_irq;
  logic              i_fiq;

  // Flush/stall controls, highest priority first
  logic              i_clear_from_writeback;
  logic              i_data_stall;
  logic              i_clear_from_alu;
  logic              i_stall_from_shifter;
  logic              i_stall_from_issue;

  // Pipeline occupancy and coprocessor completion
  logic              i_pipeline_dav;
  logic [NUM_CP-1:0] i_copro_done;

  // Towards decode
  logic [31:0]       o_instruction;
  logic              o_valid;
  logic              o_irq;
  logic              o_fiq;
  logic              o_und;
  logic              o_stall_from_decode;

  // Towards the coprocessor channels
  logic              o_copro_dav_ff;
  logic [NUM_CP-1:0] o_copro_sel_ff;
  logic [31:0]       o_copro_word_ff;
  logic [REG_W-1:0]  o_copro_reg_ff;

  modport master (
    output i_instruction, i_valid, i_cpsr_ff, i_irq, i_fiq,
    output i_clear_from_writeback, i_data_stall, i_clear_from_alu,
    output i_stall_from_shifter, i_stall_from_issue,
    output i_pipeline_dav, i_copro_done,
    input  o_instruction, o_valid, o_irq, o_fiq, o_und, o_stall_from_decode,
    input  o_copro_dav_ff, o_copro_sel_ff, o_copro_word_ff, o_copro_reg_ff
  );

  modport slave (
    input  i_instruction, i_valid, i_cpsr_ff, i_irq, i_fiq,
    input  i_clear_from_writeback, i_data_stall, i_clear_from_alu,
    input  i_stall_from_shifter, i_stall_from_issue,
    input  i_pipeline_dav, i_copro_done,
    output o_instruction, o_valid, o_irq, o_fiq, o_und, o_stall_from_decode,
    output o_copro_dav_ff, o_copro_sel_ff, o_copro_word_ff, o_copro_reg_ff
  );
endinterface

// File: rtl/zap_predecode_coproc_mc.sv
// Coprocessor dispatch stage in the ZAP predecode path.
// Detects ARM coprocessor instructions, waits for the pipeline to drain,
// hands the instruction to the channel named by its CP# field and stalls
// fetch until that channel signals done. Unmapped or timed-out requests
// are passed to decode flagged as undefined.
module zap_predecode_coproc_mc #(
  parameter int                PHY_REGS   = 46,
  parameter int                NUM_CP     = 4,
  parameter logic [NUM_CP-1:0] CP_EN_MASK = {NUM_CP{1'b1}},
  parameter int                TIMEOUT    = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  zap_predecode_coproc_mc_if.slave io_bus
);

  localparam int REG_W = $clog2(PHY_REGS);
  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  // Channel enables widened to the full 4-bit CP# space; channels beyond
  // NUM_CP read as absent.
  localparam logic [15:0]      EN16     = 16'(CP_EN_MASK);

  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Architectural register + mode -> physical register index.
  // r0-r15 map to 0-15 (USR/SYS view), FIQ banks r8-r14 at 17-23,
  // IRQ r13/r14 at 24/25, SVC 26/27, ABT 28/29, UND 30/31.
  function automatic logic [REG_W-1:0] translate(input logic [3:0] idx,
                                                 input logic [4:0] mode);
    logic [5:0] phy;
    logic       banked;
    phy    = {2'b00, idx};
    banked = (idx == 4'd13) || (idx == 4'd14);
    case (mode)
      M_FIQ: if (idx >= 4'd8 && idx <= 4'd14) phy = {2'b00, idx} + 6'd9;
      M_IRQ: if (banked) phy = (idx == 4'd13) ? 6'd24 : 6'd25;
      M_SVC: if (banked) phy = (idx == 4'd13) ? 6'd26 : 6'd27;
      M_ABT: if (banked) phy = (idx == 4'd13) ? 6'd28 : 6'd29;
      M_UND: if (banked) phy = (idx == 4'd13) ? 6'd30 : 6'd31;
      default: phy = {2'b00, idx};
    endcase
    return REG_W'(phy);
  endfunction

  state_t            r_state;
  logic              r_dav;
  logic [NUM_CP-1:0] r_sel;
  logic [31:0]       r_word;
  logic [REG_W-1:0]  r_reg;
  logic [CNT_W-1:0]  r_cnt;

  state_t            w_nxt_state;
  logic              w_nxt_dav;
  logic [NUM_CP-1:0] w_nxt_sel;
  logic [31:0]       w_nxt_word;
  logic [REG_W-1:0]  w_nxt_reg;
  logic [CNT_W-1:0]  w_nxt_cnt;

  logic [31:0]       w_ins;
  logic              w_thumb;
  logic              w_ldc_stc;
  logic              w_is_cp;
  logic [3:0]        w_cp;
  logic              w_mapped;
  logic [15:0]       w_sel16;
  logic [REG_W-1:0]  w_xlat_reg;
  logic              w_hit;
  logic              w_tmo;
  logic              w_clear;
  logic              w_load;
  logic              w_unused;

  assign w_ins      = io_bus.i_instruction;
  assign w_thumb    = io_bus.i_cpsr_ff[5];
  assign w_ldc_stc  = (w_ins[27:25] == 3'b110);
  assign w_is_cp    = io_bus.i_valid && !w_thumb &&
                      ((w_ins[27:24] == 4'b1110) || w_ldc_stc);
  assign w_cp       = w_ins[11:8];
  assign w_mapped   = EN16[w_cp];
  assign w_sel16    = 16'd1 << w_cp;
  // LDC/STC name the base register Rn; CDP/MRC/MCR name Rd.
  assign w_xlat_reg = translate(w_ldc_stc ? w_ins[19:16] : w_ins[15:12],
                                io_bus.i_cpsr_ff[4:0]);

  // Completion only counts from the channel that owns the request.
  assign w_hit = |(io_bus.i_copro_done & r_sel);
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_LAST) && !w_hit;

  // Writeback clear outranks everything; an ALU clear loses to a data stall.
  assign w_clear = io_bus.i_clear_from_writeback ||
                   (!io_bus.i_data_stall && io_bus.i_clear_from_alu);
  assign w_load  = !io_bus.i_clear_from_writeback && !io_bus.i_data_stall &&
                   !io_bus.i_clear_from_alu && !io_bus.i_stall_from_shifter &&
                   !io_bus.i_stall_from_issue;

  assign w_unused = ^{io_bus.i_cpsr_ff[31:6], w_sel16};

  // Decode-side outputs and next register values for the current state.
  always_comb begin
    io_bus.o_instruction       = w_ins;
    io_bus.o_irq               = io_bus.i_irq;
    io_bus.o_fiq               = io_bus.i_fiq;
    io_bus.o_valid             = io_bus.i_valid;
    io_bus.o_und               = 1'b0;
    io_bus.o_stall_from_decode = 1'b0;
    w_nxt_state = r_state;
    w_nxt_dav   = r_dav;
    w_nxt_sel   = r_sel;
    w_nxt_word  = r_word;
    w_nxt_reg   = r_reg;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_is_cp && !w_mapped) begin
          // No such coprocessor: pass through as undefined.
          io_bus.o_und = 1'b1;
        end else if (w_is_cp) begin
          io_bus.o_valid             = 1'b0;
          io_bus.o_stall_from_decode = 1'b1;
          if (io_bus.i_pipeline_dav) begin
            // Older instructions still in flight: wait for them to drain.
            w_nxt_dav  = 1'b0;
            w_nxt_sel  = '0;
            w_nxt_word = '0;
            w_nxt_reg  = '0;
          end else begin
            w_nxt_dav   = 1'b1;
            w_nxt_sel   = w_sel16[NUM_CP-1:0];
            w_nxt_word  = w_ins;
            w_nxt_reg   = w_xlat_reg;
            w_nxt_cnt   = '0;
            w_nxt_state = S_BUSY;
          end
        end else begin
          w_nxt_dav  = 1'b0;
          w_nxt_sel  = '0;
          w_nxt_word = '0;
          w_nxt_reg  = '0;
        end
      end
      S_BUSY: begin
        io_bus.o_valid             = 1'b0;
        io_bus.o_stall_from_decode = 1'b1;
        if (r_cnt != CNT_MAX) w_nxt_cnt = r_cnt + CNT_W'(1);
        if (w_hit || w_tmo) begin
          // Done consumes the instruction; a timeout hands it to decode
          // as undefined in the same cycle.
          io_bus.o_stall_from_decode = 1'b0;
          if (w_tmo) begin
            io_bus.o_valid = io_bus.i_valid;
            io_bus.o_und   = 1'b1;
          end
          w_nxt_dav   = 1'b0;
          w_nxt_sel   = '0;
          w_nxt_word  = '0;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State and coprocessor request registers with clear/hold priority.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_dav   <= 1'b0;
      r_sel   <= '0;
      r_word  <= '0;
      r_reg   <= '0;
      r_cnt   <= '0;
    end else if (w_clear) begin
      r_state <= S_IDLE;
      r_dav   <= 1'b0;
      r_sel   <= '0;
      r_word  <= '0;
      r_reg   <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= w_nxt_state;
      r_dav   <= w_nxt_dav;
      r_sel   <= w_nxt_sel;
      r_word  <= w_nxt_word;
      r_reg   <= w_nxt_reg;
      r_cnt   <= w_nxt_cnt;
    end
  end

  assign io_bus.o_copro_dav_ff  = r_dav;
  assign io_bus.o_copro_sel_ff  = r_sel;
  assign io_bus.o_copro_word_ff = r_word;
  assign io_bus.o_copro_reg_ff  = r_reg;

endmodule
